input_mapper: RTL and testbench



---
 rtl/cave_input_pkg.sv | 88 ++++++++
 rtl/coin_stretcher.sv | 31 +++
 rtl/input_mapper.sv | 134 +++++++++++++
 tb/tb_input_mapper.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cave_input_pkg.sv
// Shared constants for the cabinet input path: PS/2 scan codes, joystick word layout
// and the flat key-register index map used by input_mapper.
package cave_input_pkg;

    localparam int JOY_STRIDE = 16;
    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_BTN    = 4;
    localparam int JOY_START  = 12;
    localparam int JOY_COIN   = 13;
    localparam int JOY_PAUSE  = 14;

    // Key slots per keyboard player, ordered like the joystick low bits so they OR directly
    localparam int KEY_SLOTS   = 10;
    localparam int SLOT_RIGHT  = 0;
    localparam int SLOT_LEFT   = 1;
    localparam int SLOT_DOWN   = 2;
    localparam int SLOT_UP     = 3;
    localparam int SLOT_BTN    = 4;
    localparam int SLOT_START  = 7;
    localparam int SLOT_COIN   = 8;
    localparam int SLOT_PAUSE  = 9;
    localparam int KEY_PLAYERS = 2;
    localparam int KEY_BUTTONS = 3;
    localparam int KEY_SVC     = KEY_PLAYERS * KEY_SLOTS;
    localparam int NUM_KEYS    = KEY_SVC + 2;

    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_BTN1  = 8'h14;
    localparam logic [7:0] SC_P1_BTN2  = 8'h11;
    localparam logic [7:0] SC_P1_BTN3  = 8'h29;
    localparam logic [7:0] SC_P1_START = 8'h16;
    localparam logic [7:0] SC_P1_COIN  = 8'h2E;
    localparam logic [7:0] SC_P1_PAUSE = 8'h4D;
    localparam logic [7:0] SC_P2_UP    = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] SC_P2_BTN1  = 8'h1C;
    localparam logic [7:0] SC_P2_BTN2  = 8'h1B;
    localparam logic [7:0] SC_P2_BTN3  = 8'h15;
    localparam logic [7:0] SC_P2_START = 8'h1E;
    localparam logic [7:0] SC_P2_COIN  = 8'h36;
    localparam logic [7:0] SC_SVC1     = 8'h46;
    localparam logic [7:0] SC_SVC2     = 8'h45;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_hit_t;

    function automatic key_hit_t key_lookup(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = '0;
        case (code)
            SC_P1_RIGHT: r.idx = 5'(SLOT_RIGHT);
            SC_P1_LEFT:  r.idx = 5'(SLOT_LEFT);
            SC_P1_DOWN:  r.idx = 5'(SLOT_DOWN);
            SC_P1_UP:    r.idx = 5'(SLOT_UP);
            SC_P1_BTN1:  r.idx = 5'(SLOT_BTN);
            SC_P1_BTN2:  r.idx = 5'(SLOT_BTN + 1);
            SC_P1_BTN3:  r.idx = 5'(SLOT_BTN + 2);
            SC_P1_START: r.idx = 5'(SLOT_START);
            SC_P1_COIN:  r.idx = 5'(SLOT_COIN);
            SC_P1_PAUSE: r.idx = 5'(SLOT_PAUSE);
            SC_P2_RIGHT: r.idx = 5'(KEY_SLOTS + SLOT_RIGHT);
            SC_P2_LEFT:  r.idx = 5'(KEY_SLOTS + SLOT_LEFT);
            SC_P2_DOWN:  r.idx = 5'(KEY_SLOTS + SLOT_DOWN);
            SC_P2_UP:    r.idx = 5'(KEY_SLOTS + SLOT_UP);
            SC_P2_BTN1:  r.idx = 5'(KEY_SLOTS + SLOT_BTN);
            SC_P2_BTN2:  r.idx = 5'(KEY_SLOTS + SLOT_BTN + 1);
            SC_P2_BTN3:  r.idx = 5'(KEY_SLOTS + SLOT_BTN + 2);
            SC_P2_START: r.idx = 5'(KEY_SLOTS + SLOT_START);
            SC_P2_COIN:  r.idx = 5'(KEY_SLOTS + SLOT_COIN);
            SC_SVC1:     r.idx = 5'(KEY_SVC);
            SC_SVC2:     r.idx = 5'(KEY_SVC + 1);
            default:     r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/coin_stretcher.sv
// Stretches a coin press into a fixed-length pulse; a new press while active restarts it.
module coin_stretcher #(
    parameter int COIN_CYCLES = 2048
) (
    input  logic clk_sys,
    input  logic reset_sys_n,
    input  logic coin_in,
    output logic coin_out
);

    localparam int CW = $clog2(COIN_CYCLES) + 1;

    logic [CW-1:0] cnt_q;
    logic          coin_prev_q;

    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            cnt_q       <= '0;
            coin_prev_q <= 1'b0;
        end else begin
            coin_prev_q <= coin_in;
            if (coin_in && !coin_prev_q)
                cnt_q <= CW'(COIN_CYCLES);
            else if (cnt_q != '0)
                cnt_q <= cnt_q - CW'(1);
        end
    end

    assign coin_out = (cnt_q != '0);

endmodule

// File: rtl/input_mapper.sv
// Merges PS/2 keyboard and joystick controls per player, with coin stretching,
// shared autofire gating and level/toggle pause.
module input_mapper
    import cave_input_pkg::*;
#(
    parameter int PLAYERS      = 2,
    parameter int BUTTONS      = 3,
    parameter int COIN_CYCLES  = 2048,
    parameter int AUTOFIRE_DIV = 65536
) (
    input  logic                         clk_sys,
    input  logic                         reset_sys_n,
    input  logic [10:0]                  ps2_key,
    input  logic [PLAYERS*JOY_STRIDE-1:0] joystick,
    input  logic [PLAYERS*BUTTONS-1:0]   autofire_en,
    input  logic                         pause_mode,
    output logic [PLAYERS*4-1:0]         dir,
    output logic [PLAYERS*BUTTONS-1:0]   buttons,
    output logic [PLAYERS-1:0]           start,
    output logic [PLAYERS-1:0]           coin,
    output logic [1:0]                   service,
    output logic                         pause
);

    localparam int AW = $clog2(AUTOFIRE_DIV) + 1;

    logic                 tog_q;
    logic                 armed_q;
    logic [NUM_KEYS-1:0]  key_q;
    key_hit_t             hit;
    logic                 key_event;

    assign hit       = key_lookup(ps2_key[7:0]);
    // armed_q stays low for the first cycle after reset so the toggle bit is captured silently
    assign key_event = armed_q && (ps2_key[10] != tog_q);

    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            key_q   <= '0;
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
            if (key_event && hit.hit)
                key_q[hit.idx] <= ps2_key[9];
        end
    end

    logic [PLAYERS*4-1:0]       m_dir;
    logic [PLAYERS*BUTTONS-1:0] m_btn;
    logic [PLAYERS-1:0]         m_start;
    logic [PLAYERS-1:0]         m_coin;
    logic [PLAYERS-1:0]         m_pause;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [KEY_SLOTS-1:0] pk;
        if (p < KEY_PLAYERS) begin : g_keys
            assign pk = key_q[p*KEY_SLOTS +: KEY_SLOTS];
        end else begin : g_nokeys
            assign pk = '0;
        end

        assign m_dir[p*4 +: 4] = joystick[p*JOY_STRIDE + JOY_RIGHT +: 4] | pk[SLOT_RIGHT +: 4];
        for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
            if (b < KEY_BUTTONS) begin : g_keyed
                assign m_btn[p*BUTTONS + b] = joystick[p*JOY_STRIDE + JOY_BTN + b] | pk[SLOT_BTN + b];
            end else begin : g_joy_only
                assign m_btn[p*BUTTONS + b] = joystick[p*JOY_STRIDE + JOY_BTN + b];
            end
        end
        assign m_start[p] = joystick[p*JOY_STRIDE + JOY_START] | pk[SLOT_START];
        assign m_coin[p]  = joystick[p*JOY_STRIDE + JOY_COIN]  | pk[SLOT_COIN];
        assign m_pause[p] = joystick[p*JOY_STRIDE + JOY_PAUSE] | pk[SLOT_PAUSE];

        coin_stretcher #(.COIN_CYCLES(COIN_CYCLES)) u_coin (
            .clk_sys     (clk_sys),
            .reset_sys_n (reset_sys_n),
            .coin_in     (m_coin[p]),
            .coin_out    (coin[p])
        );
    end

    logic [AW-1:0]              af_cnt_q;
    logic                       af_phase_q;
    logic                       af_phase_nx;
    logic [PLAYERS*BUTTONS-1:0] btn_prev_q;
    logic                       af_restart;
    logic                       af_wrap;

    assign af_restart  = |(m_btn & ~btn_prev_q & autofire_en);
    assign af_wrap     = (af_cnt_q == AW'(AUTOFIRE_DIV - 1));
    // Gate with the upcoming phase so a fresh press fires on its very first output cycle
    assign af_phase_nx = af_restart ? 1'b1 : (af_wrap ? ~af_phase_q : af_phase_q);

    logic pause_or;
    logic pause_prev_q;
    logic latch_q;
    logic latch_nx;

    assign pause_or = |m_pause;
    assign latch_nx = !pause_mode ? 1'b0 :
                      ((pause_or && !pause_prev_q) ? ~latch_q : latch_q);

    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            af_cnt_q     <= '0;
            af_phase_q   <= 1'b1;
            btn_prev_q   <= '0;
            pause_prev_q <= 1'b0;
            latch_q      <= 1'b0;
            dir          <= '0;
            buttons      <= '0;
            start        <= '0;
            service      <= '0;
            pause        <= 1'b0;
        end else begin
            btn_prev_q   <= m_btn;
            af_phase_q   <= af_phase_nx;
            af_cnt_q     <= (af_restart || af_wrap) ? '0 : af_cnt_q + AW'(1);
            pause_prev_q <= pause_or;
            latch_q      <= latch_nx;
            dir          <= m_dir;
            buttons      <= m_btn & (~autofire_en | {(PLAYERS*BUTTONS){af_phase_nx}});
            start        <= m_start;
            service      <= key_q[KEY_SVC +: 2];
            pause        <= pause_mode ? latch_nx : pause_or;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{ps2_key[8], joystick};

endmodule

// File: tb/tb_input_mapper.sv
// Directed-vector bench for input_mapper with short coin and autofire periods.
module tb_input_mapper;

    localparam int PLAYERS = 2;
    localparam int BUTTONS = 3;

    logic                     clk_sys = 1'b0;
    logic                     reset_sys_n;
    logic [10:0]              ps2_key;
    logic [PLAYERS*16-1:0]    joystick;
    logic [PLAYERS*BUTTONS-1:0] autofire_en;
    logic                     pause_mode;
    logic [PLAYERS*4-1:0]     dir;
    logic [PLAYERS*BUTTONS-1:0] buttons;
    logic [PLAYERS-1:0]       start;
    logic [PLAYERS-1:0]       coin;
    logic [1:0]               service;
    logic                     pause;

    int vector_count    = 0;
    int miscompare_count = 0;

    input_mapper #(
        .PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .COIN_CYCLES(8), .AUTOFIRE_DIV(4)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_sys_n (reset_sys_n),
        .ps2_key     (ps2_key),
        .joystick    (joystick),
        .autofire_en (autofire_en),
        .pause_mode  (pause_mode),
        .dir         (dir),
        .buttons     (buttons),
        .start       (start),
        .coin        (coin),
        .service     (service),
        .pause       (pause)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        vector_count++;
        if (got !== want) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] joy, input logic [5:0] af_en, input logic pmode);
        joystick    = joy;
        autofire_en = af_en;
        pause_mode  = pmode;
    endtask

    task automatic send_key(input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    initial begin
        reset_sys_n = 1'b0;
        ps2_key     = '0;
        apply_stimulus(32'h0, 6'h0, 1'b0);
        tick();
        tick();
        check_output("reset dir", 32'(dir), 32'h0);
        check_output("reset buttons", 32'(buttons), 32'h0);
        check_output("reset start/coin", 32'({start, coin}), 32'h0);
        check_output("reset service/pause", 32'({service, pause}), 32'h0);
        check_output("reset autofire phase", 32'(dut.af_phase_q), 32'h1);
        reset_sys_n = 1'b1;
        tick();

        // keyboard: p1 up press then release, two-cycle latency each way
        send_key(8'h75, 1'b1);
        tick();
        check_output("kbd up after 1", 32'(dir), 32'h00);
        tick();
        check_output("kbd up after 2", 32'(dir), 32'h08);
        send_key(8'h75, 1'b0);
        tick();
        check_output("kbd up rel after 1", 32'(dir), 32'h08);
        tick();
        check_output("kbd up rel after 2", 32'(dir), 32'h00);

        send_key(8'h1C, 1'b1);
        tick();
        tick();
        check_output("kbd p2 btn1", 32'(buttons), 32'h08);
        send_key(8'h1C, 1'b0);
        tick();
        tick();
        check_output("kbd p2 btn1 rel", 32'(buttons), 32'h00);

        // joystick: one-cycle latency
        apply_stimulus(32'h0001_1008, 6'h0, 1'b0);
        tick();
        check_output("joy dirs", 32'(dir), 32'h18);
        check_output("joy start", 32'(start), 32'h1);
        apply_stimulus(32'h0, 6'h0, 1'b0);
        tick();
        check_output("joy dirs clear", 32'(dir), 32'h00);

        // single coin pulse
        apply_stimulus(32'h0000_2000, 6'h0, 1'b0);
        tick();
        apply_stimulus(32'h0, 6'h0, 1'b0);
        check_output("coin k1", 32'(coin[0]), 32'h1);
        for (int k = 2; k <= 10; k++) begin
            tick();
            check_output($sformatf("coin k%0d", k), 32'(coin[0]), 32'(k <= 8));
        end

        // retriggered coin pulse
        apply_stimulus(32'h0000_2000, 6'h0, 1'b0);
        tick();
        apply_stimulus(32'h0, 6'h0, 1'b0);
        for (int k = 2; k <= 14; k++) begin
            if (k == 5) apply_stimulus(32'h0000_2000, 6'h0, 1'b0);
            tick();
            apply_stimulus(32'h0, 6'h0, 1'b0);
            check_output($sformatf("coin retrig k%0d", k), 32'(coin[0]), 32'(k <= 12));
        end

        // autofire on p1 button 1, plain hold on p1 button 2
        apply_stimulus(32'h0000_0030, 6'h01, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_output($sformatf("autofire k%0d", k), 32'(buttons[1:0]),
                         32'({1'b1, (((k - 1) / 4) % 2) == 0}));
        end
        apply_stimulus(32'h0, 6'h0, 1'b0);
        tick();

        // toggle pause: simultaneous press counts once
        apply_stimulus(32'h4000_4000, 6'h0, 1'b1);
        tick();
        check_output("pause toggle on", 32'(pause), 32'h1);
        tick();
        check_output("pause hold", 32'(pause), 32'h1);
        apply_stimulus(32'h0, 6'h0, 1'b1);
        tick();
        check_output("pause released", 32'(pause), 32'h1);
        apply_stimulus(32'h0000_4000, 6'h0, 1'b1);
        tick();
        check_output("pause toggle off", 32'(pause), 32'h0);
        apply_stimulus(32'h0, 6'h0, 1'b0);
        tick();
        check_output("pause level idle", 32'(pause), 32'h0);
        apply_stimulus(32'h4000_0000, 6'h0, 1'b0);
        tick();
        check_output("pause level p2", 32'(pause), 32'h1);
        apply_stimulus(32'h0, 6'h0, 1'b0);
        tick();
        check_output("pause level low", 32'(pause), 32'h0);
        send_key(8'h4D, 1'b1);
        tick();
        tick();
        check_output("pause key", 32'(pause), 32'h1);
        send_key(8'h4D, 1'b0);
        tick();
        tick();
        check_output("pause key rel", 32'(pause), 32'h0);

        // service keys and an unmapped code
        send_key(8'h46, 1'b1);
        tick();
        tick();
        check_output("service 1", 32'(service), 32'h1);
        send_key(8'h99, 1'b1);
        tick();
        tick();
        check_output("code 99 service", 32'(service), 32'h1);
        check_output("code 99 dir/btn", 32'({dir, buttons, start}), 32'h0);
        send_key(8'h45, 1'b1);
        tick();
        tick();
        check_output("service both", 32'(service), 32'h3);

        // reset in the middle of a coin pulse
        apply_stimulus(32'h0000_2000, 6'h0, 1'b0);
        tick();
        apply_stimulus(32'h0, 6'h0, 1'b0);
        tick();
        check_output("coin before reset", 32'(coin[0]), 32'h1);
        reset_sys_n = 1'b0;
        #1;
        check_output("coin in reset", 32'(coin[0]), 32'h0);
        tick();
        reset_sys_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_output($sformatf("coin after reset k%0d", k), 32'(coin[0]), 32'h0);
        end
        check_output("service after reset", 32'(service), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
